seq_cycle_counter: RTL and testbench

Parametrised synchronous cycle counter that sequences multi-cycle processor operations such as 32-step multiply/divide.
- Replaces fixed 5-bit free-running counting with a start/run/terminal-count controller.
- Adds enable gating, abort, a one-cycle done pulse, and a one-shot or auto-reload mode.
- Sits beside the multdiv datapath; its done output drives the result-ready and stall logic.

---
 rtl/seq_counter_pkg.sv | 12 +
 rtl/seq_cycle_counter.sv | 130 +++++++++++++
 tb/tb_seq_cycle_counter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_counter_pkg.sv
// Shared types and default constants for the sequenced cycle counter.
package seq_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CNT_WIDTH_DEF    = 5;
    localparam int CNT_TERMINAL_DEF = 31;

endpackage : seq_counter_pkg

// File: rtl/seq_cycle_counter.sv
// Start/run/terminal-count controller for multi-cycle multiply/divide sequencing.
// Optional direct-load ports are enabled by defining SEQ_CYCLE_COUNTER_LOAD_EN.
module seq_cycle_counter
    import seq_counter_pkg::*;
#(
    parameter int WIDTH       = CNT_WIDTH_DEF,
    parameter int TERMINAL    = CNT_TERMINAL_DEF,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             enable,
    input  logic             abort,
`ifdef SEQ_CYCLE_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    if ((TERMINAL < 0) || (TERMINAL > ((2 ** WIDTH) - 1))) begin : g_bad_terminal
        $error("seq_cycle_counter: TERMINAL %0d does not fit in %0d bits", TERMINAL, WIDTH);
    end

    localparam logic [WIDTH-1:0] TERM_C = WIDTH'(TERMINAL);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1'b1);

`ifdef SEQ_CYCLE_COUNTER_LOAD_EN
    // Loaded values past the terminal count would otherwise run until natural overflow.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
        if (val > TERM_C) begin
            return TERM_C;
        end else begin
            return val;
        end
    endfunction
`endif

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;
    logic             busy_r;
    logic             busy_s;
    logic             done_r;
    logic             done_s;

    // Next-state, next-count and terminal-event decode.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
`ifdef SEQ_CYCLE_COUNTER_LOAD_EN
                if (load) begin
                    count_s = clamp_load(load_val);
                    state_s = RUN;
                end else
`endif
                if (start) begin
                    count_s = ZERO_C;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    count_s = ZERO_C;
                    state_s = IDLE;
                end else
`ifdef SEQ_CYCLE_COUNTER_LOAD_EN
                if (load) begin
                    count_s = clamp_load(load_val);
                    state_s = RUN;
                end else
`endif
                if (start) begin
                    count_s = ZERO_C;
                    state_s = RUN;
                end else if (enable) begin
                    if (count_r == TERM_C) begin
                        done_s = 1'b1;
                        // One-shot parks on TERMINAL so the final step index stays readable.
                        if (AUTO_RELOAD != 0) begin
                            count_s = ZERO_C;
                            state_s = RUN;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        count_s = count_r + ONE_C;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                count_s = ZERO_C;
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            count_r <= ZERO_C;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign count = count_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule : seq_cycle_counter

// File: tb/tb_seq_cycle_counter.sv
// Directed self-checking bench for seq_cycle_counter (one-shot, auto-reload, TERMINAL=0,
// and the SEQ_CYCLE_COUNTER_LOAD_EN load path when that macro is defined).
module tb_seq_cycle_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       enable;
    logic       abort;
`ifdef SEQ_CYCLE_COUNTER_LOAD_EN
    logic       load;
    logic [4:0] load_val5;
    logic [5:0] load_val6;
    logic [5:0] cnt_w6;
    logic       busy_w6;
    logic       done_w6;
`endif
    logic [4:0] cnt_def;
    logic       busy_def;
    logic       done_def;
    logic [4:0] cnt_ar;
    logic       busy_ar;
    logic       done_ar;
    logic [4:0] cnt_t0;
    logic       busy_t0;
    logic       done_t0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_cycle_counter u_def (
        .clk(clk), .rst(rst), .start(start), .enable(enable), .abort(abort),
`ifdef SEQ_CYCLE_COUNTER_LOAD_EN
        .load(load), .load_val(load_val5),
`endif
        .count(cnt_def), .busy(busy_def), .done(done_def)
    );

    seq_cycle_counter #(.WIDTH(5), .TERMINAL(3), .AUTO_RELOAD(1)) u_ar (
        .clk(clk), .rst(rst), .start(start), .enable(enable), .abort(abort),
`ifdef SEQ_CYCLE_COUNTER_LOAD_EN
        .load(load), .load_val(load_val5),
`endif
        .count(cnt_ar), .busy(busy_ar), .done(done_ar)
    );

    seq_cycle_counter #(.WIDTH(5), .TERMINAL(0), .AUTO_RELOAD(1)) u_t0 (
        .clk(clk), .rst(rst), .start(start), .enable(enable), .abort(abort),
`ifdef SEQ_CYCLE_COUNTER_LOAD_EN
        .load(load), .load_val(load_val5),
`endif
        .count(cnt_t0), .busy(busy_t0), .done(done_t0)
    );

`ifdef SEQ_CYCLE_COUNTER_LOAD_EN
    seq_cycle_counter #(.WIDTH(6), .TERMINAL(31), .AUTO_RELOAD(0)) u_w6 (
        .clk(clk), .rst(rst), .start(start), .enable(enable), .abort(abort),
        .load(load), .load_val(load_val6),
        .count(cnt_w6), .busy(busy_w6), .done(done_w6)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; enable = 1'b0; abort = 1'b0;
`ifdef SEQ_CYCLE_COUNTER_LOAD_EN
        load = 1'b0; load_val5 = 5'd0; load_val6 = 6'd0;
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({cnt_def, busy_def, done_def} !== {5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got cnt=%0d busy=%b done=%b, want cnt=0 busy=0 done=0",
                     cnt_def, busy_def, done_def);
        end
    endtask

    task automatic test_one_shot();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({cnt_def, busy_def, done_def} !== {5'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL one_shot_start: got cnt=%0d busy=%b done=%b, want cnt=0 busy=1 done=0",
                     cnt_def, busy_def, done_def);
        end
        enable = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            n_checks++;
            if ({cnt_def, busy_def, done_def} !== {5'(k), 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL one_shot_edge%0d: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=1 done=0",
                         k, cnt_def, busy_def, done_def, k);
            end
        end
        tick();
        n_checks++;
        if ({cnt_def, busy_def, done_def} !== {5'd31, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL one_shot_done: got cnt=%0d busy=%b done=%b, want cnt=31 busy=0 done=1",
                     cnt_def, busy_def, done_def);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({cnt_def, busy_def, done_def} !== {5'd31, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL one_shot_after%0d: got cnt=%0d busy=%b done=%b, want cnt=31 busy=0 done=0",
                         k, cnt_def, busy_def, done_def);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_toggle_enable();
        logic [4:0] exp_cnt;
        logic       exp_busy;
        logic       exp_done;
        int         pulses;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_cnt = 5'd0; exp_busy = 1'b1; pulses = 0;
        for (int i = 0; i < 70; i++) begin
            enable = ((i % 2) == 0);
            tick();
            exp_done = 1'b0;
            if (exp_busy && enable) begin
                if (exp_cnt == 5'd31) begin
                    exp_done = 1'b1;
                    exp_busy = 1'b0;
                end else begin
                    exp_cnt = exp_cnt + 5'd1;
                end
            end
            if (done_def === 1'b1) pulses++;
            n_checks++;
            if ({cnt_def, busy_def, done_def} !== {exp_cnt, exp_busy, exp_done}) begin
                n_fail++;
                $display("FAIL toggle_cycle%0d: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
                         i, cnt_def, busy_def, done_def, exp_cnt, exp_busy, exp_done);
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL toggle_pulses: got %0d done pulses, want 1", pulses);
        end
        enable = 1'b0;
    endtask

    task automatic test_abort();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        n_checks++;
        if (cnt_def !== 5'd10) begin
            n_fail++;
            $display("FAIL abort_pre: got cnt=%0d, want 10", cnt_def);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({cnt_def, busy_def, done_def} !== {5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_edge: got cnt=%0d busy=%b done=%b, want cnt=0 busy=0 done=0",
                     cnt_def, busy_def, done_def);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({cnt_def, busy_def, done_def} !== {5'd0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL abort_idle%0d: got cnt=%0d busy=%b done=%b, want cnt=0 busy=0 done=0",
                         k, cnt_def, busy_def, done_def);
            end
        end
        enable = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 31; k++) tick();
        n_checks++;
        if ({cnt_def, busy_def, done_def} !== {5'd31, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_rerun31: got cnt=%0d busy=%b done=%b, want cnt=31 busy=1 done=0",
                     cnt_def, busy_def, done_def);
        end
        tick();
        n_checks++;
        if ({cnt_def, busy_def, done_def} !== {5'd31, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_rerun_done: got cnt=%0d busy=%b done=%b, want cnt=31 busy=0 done=1",
                     cnt_def, busy_def, done_def);
        end
        enable = 1'b0;
    endtask

    task automatic test_restart();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({cnt_def, busy_def, done_def} !== {5'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL restart_edge: got cnt=%0d busy=%b done=%b, want cnt=0 busy=1 done=0",
                     cnt_def, busy_def, done_def);
        end
        for (int k = 1; k <= 31; k++) begin
            tick();
            n_checks++;
            if ({cnt_def, busy_def, done_def} !== {5'(k), 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL restart_edge%0d: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=1 done=0",
                         k, cnt_def, busy_def, done_def, k);
            end
        end
        tick();
        n_checks++;
        if ({cnt_def, busy_def, done_def} !== {5'd31, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL restart_done: got cnt=%0d busy=%b done=%b, want cnt=31 busy=0 done=1",
                     cnt_def, busy_def, done_def);
        end
        enable = 1'b0;
    endtask

    task automatic test_auto_reload();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++;
            if ({cnt_ar, busy_ar, done_ar} !== {5'(k % 4), 1'b1, ((k % 4) == 0)}) begin
                n_fail++;
                $display("FAIL auto_reload_edge%0d: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=1 done=%0d",
                         k, cnt_ar, busy_ar, done_ar, k % 4, (k % 4) == 0);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({cnt_t0, busy_t0, done_t0} !== {5'd0, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL b2b_edge%0d: got cnt=%0d busy=%b done=%b, want cnt=0 busy=1 done=1",
                         k, cnt_t0, busy_t0, done_t0);
            end
        end
        enable = 1'b0;
        tick();
        n_checks++;
        if ({cnt_t0, busy_t0, done_t0} !== {5'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_hold: got cnt=%0d busy=%b done=%b, want cnt=0 busy=1 done=0",
                     cnt_t0, busy_t0, done_t0);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 31; k++) tick();
        n_checks++;
        if (cnt_def !== 5'd31) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got cnt=%0d, want 31", cnt_def);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        enable = 1'b0;
        n_checks++;
        if ({cnt_def, busy_def, done_def} !== {5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid: got cnt=%0d busy=%b done=%b, want cnt=0 busy=0 done=0",
                     cnt_def, busy_def, done_def);
        end
        tick();
        n_checks++;
        if ({cnt_def, busy_def, done_def} !== {5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_after: got cnt=%0d busy=%b done=%b, want cnt=0 busy=0 done=0",
                     cnt_def, busy_def, done_def);
        end
    endtask

`ifdef SEQ_CYCLE_COUNTER_LOAD_EN
    task automatic test_load();
        do_reset();
        load = 1'b1; load_val5 = 5'd28; load_val6 = 6'd40;
        tick();
        load = 1'b0;
        n_checks++;
        if ({cnt_def, busy_def, done_def} !== {5'd28, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL load28: got cnt=%0d busy=%b done=%b, want cnt=28 busy=1 done=0",
                     cnt_def, busy_def, done_def);
        end
        n_checks++;
        if ({cnt_w6, busy_w6, done_w6} !== {6'd31, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL load_clamp: got cnt=%0d busy=%b done=%b, want cnt=31 busy=1 done=0",
                     cnt_w6, busy_w6, done_w6);
        end
        enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if ({cnt_def, busy_def, done_def} !== {5'(28 + k), 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL load_edge%0d: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=1 done=0",
                         k, cnt_def, busy_def, done_def, 28 + k);
            end
        end
        tick();
        n_checks++;
        if ({cnt_def, busy_def, done_def} !== {5'd31, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL load_done: got cnt=%0d busy=%b done=%b, want cnt=31 busy=0 done=1",
                     cnt_def, busy_def, done_def);
        end
        enable = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; enable = 1'b0; abort = 1'b0;
`ifdef SEQ_CYCLE_COUNTER_LOAD_EN
        load = 1'b0; load_val5 = 5'd0; load_val6 = 6'd0;
`endif
        test_reset();
        test_one_shot();
        test_toggle_enable();
        test_abort();
        test_restart();
        test_auto_reload();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SEQ_CYCLE_COUNTER_LOAD_EN
        test_load();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_cycle_counter
